// File: rtl/serial_adder_pkg.sv
// Shared FSM state encodings and the default operand width for the serial adder.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/Full_adder_18ec068_behavioral.sv
// Behavioral one-bit full-adder cell: s = a ^ b ^ c, car = majority(a, b, c).
module Full_adder_18ec068_behavioral (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic car
);

    assign s   = a ^ b ^ c;
    assign car = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_18ec068.sv
// Bit-serial adder: one full-adder cell, one result bit per clock, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_adder_18ec068
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_car;

    Full_adder_18ec068_behavioral u_fa (
        .a   (a_reg[0]),
        .b   (b_reg[0]),
        .c   (carry),
        .s   (fa_s),
        .car (fa_car)
    );

    // Sum bits enter at the MSB and shift right, so after WIDTH cycles bit 0 holds the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum_out <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg   <= a_in;
                        b_reg   <= b_in;
                        carry   <= cin;
                        cnt     <= '0;
                        sum_out <= '0;
                        cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf     <= 1'b0;
`endif
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    sum_out <= {fa_s, sum_out[WIDTH-1:1]};
                    carry   <= fa_car;
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        // carry still holds the carry into the MSB on this final bit.
                        cout  <= fa_car;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= carry ^ fa_car;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_18ec068.sv
// Directed self-checking bench for serial_adder_18ec068 (WIDTH=8); overflow cases build with SERIAL_ADDER_OVF_EN.
module tb_serial_adder_18ec068;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int compared;
    int mismatched;

    serial_adder_18ec068 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf     (ovf),
`endif
        .cout    (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    // Starts an addition and walks the 8 bit-cycles; pokeAt re-pulses start, rstAt aborts with reset.
    task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                                 input logic [7:0] expSum, input logic expCout, input logic expOvf,
                                 input int pokeAt, input int rstAt);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        cin   = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = 8'h00;
        b_in  = 8'h00;
        cin   = 1'b0;
        checkOutput({tag, " busy@T0"}, 32'(busy), 32'd1);
        checkOutput({tag, " sum cleared"}, 32'(sum_out), 32'd0);
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            if (k == pokeAt) begin
                a_in  = 8'h01;
                b_in  = 8'h01;
                cin   = 1'b1;
                start = 1'b1;
            end
            if (k == rstAt) rst = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            rst   = 1'b0;
            a_in  = 8'h00;
            b_in  = 8'h00;
            cin   = 1'b0;
            if (k == rstAt) begin
                checkOutput({tag, " abort busy"}, 32'(busy), 32'd0);
                checkOutput({tag, " abort done"}, 32'(done), 32'd0);
                checkOutput({tag, " abort sum"}, 32'(sum_out), 32'd0);
                checkOutput({tag, " abort cout"}, 32'(cout), 32'd0);
                for (int j = 0; j < W + 2; j++) begin
                    @(posedge clk);
                    #1;
                    checkOutput({tag, " no done after abort"}, 32'(done), 32'd0);
                end
                return;
            end
            if (k < W) begin
                checkOutput({tag, " busy mid"}, 32'(busy), 32'd1);
                checkOutput({tag, " done mid"}, 32'(done), 32'd0);
            end else begin
                checkOutput({tag, " busy end"}, 32'(busy), 32'd0);
                checkOutput({tag, " done pulse"}, 32'(done), 32'd1);
            end
        end
        checkOutput({tag, " sum"}, 32'(sum_out), 32'(expSum));
        checkOutput({tag, " cout"}, 32'(cout), 32'(expCout));
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput({tag, " ovf"}, 32'(ovf), 32'(expOvf));
`else
        if (expOvf === 1'bx) $display("[TB] note: unknown overflow expectation");
`endif
        for (int j = 0; j < 2; j++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, " done low after"}, 32'(done), 32'd0);
            checkOutput({tag, " sum held"}, 32'(sum_out), 32'(expSum));
            checkOutput({tag, " cout held"}, 32'(cout), 32'(expCout));
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = 8'h00;
        b_in  = 8'h00;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset sum", 32'(sum_out), 32'd0);
        checkOutput("reset cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("reset ovf", 32'(ovf), 32'd0);
`endif

        // Reset wins over a simultaneous start.
        @(negedge clk);
        start = 1'b1;
        a_in  = 8'h12;
        b_in  = 8'h34;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        checkOutput("rst over start busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst over start idle", 32'(busy), 32'd0);

        $display("[TB] case 1: 0x55 + 0xAA");
        applyStimulus("c1", 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0, 0, 0);
        $display("[TB] case 2: 0xFF + 0x01");
        applyStimulus("c2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0);
        $display("[TB] case 3: 0xFF + 0xFF + 1");
        applyStimulus("c3", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 0);
        $display("[TB] case 4: ignored start during SHIFT");
        applyStimulus("c4", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 3, 0);
        $display("[TB] case 5: reset mid-operation then fresh add");
        applyStimulus("c5a", 8'h0F, 8'h0F, 1'b0, 8'h00, 1'b0, 1'b0, 0, 4);
        applyStimulus("c5b", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 0, 0);
        applyStimulus("c7", 8'hA5, 8'h3C, 1'b1, 8'hE2, 1'b0, 1'b0, 0, 0);
`ifdef SERIAL_ADDER_OVF_EN
        $display("[TB] case 6: overflow");
        applyStimulus("c6a", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, 0);
        applyStimulus("c6b", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/serial_adder_18ec068.md
SERIAL_ADDER_18EC068 -- requirements
Module: serial_adder_18ec068

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  rising-edge clock; the block has one clock; reset is synchronous and active-high.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a_in  input  WIDTH  operand A, captured on the accepted start.
REQ-006 b_in  input  WIDTH  operand B, captured on the accepted start.
REQ-007 cin  input  1  carry-in, captured on the accepted start.
REQ-008 busy  output  1  high while the addition is in progress (SHIFT state).
REQ-009 done  output  1  one-cycle pulse when the result is valid.
REQ-010 sum_out  output  WIDTH  registered sum.
REQ-011 cout  output  1  registered carry-out.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 Transitions SHALL be: IDLE->SHIFT on start; SHIFT->DONE after WIDTH bit-cycles; DONE->IDLE unconditionally.
REQ-014 On an accepted start, the block SHALL load a_in and b_in into shift registers, load cin into the carry flop, clear the bit counter and clear sum_out.
REQ-015 Each SHIFT cycle SHALL add the LSBs of A and B plus the carry through one full-adder cell, shift the sum bit into sum_out MSB-first (right-shift), update the carry flop, shift A and B right by one and increment the counter.
REQ-016 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL leave SHIFT when it reaches WIDTH-1 on the current cycle's bit.
REQ-017 Latency: with start sampled at edge T0, done SHALL be high only during the cycle following edge T0+WIDTH.
REQ-018 sum_out and cout SHALL hold the final result from DONE until the next accepted start.
REQ-019 The block SHALL ignore start in SHIFT and DONE states, with no state or data change.
REQ-020 The block SHALL never drive busy and done high in the same cycle.
REQ-021 sum_out SHALL equal (a_in + b_in + cin) mod 2^WIDTH, and cout SHALL be bit WIDTH of that full sum.

Reset
REQ-022 While rst is high at a clock edge, the block SHALL enter IDLE and SHALL clear busy, done, sum_out, cout, the carry flop, the counter and the operand registers to 0.
REQ-023 An rst asserted mid-operation SHALL abort the addition without generating a done pulse.
REQ-024 rst SHALL have priority over start when both are high at the same edge.

Configuration
REQ-025 When SERIAL_ADDER_OVF_EN is defined, the block SHALL add output ovf (1 bit), registered at DONE, equal to carry-into-MSB XOR carry-out of MSB (two's-complement overflow).
REQ-026 ovf SHALL reset to 0, SHALL hold with sum_out, and SHALL clear on an accepted start.
REQ-027 When SERIAL_ADDER_OVF_EN is not defined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 The state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the WIDTH default SHALL reside in the shared package/include serial_adder_pkg.
REQ-029 The one-bit add SHALL be a single instance of the existing behavioral full-adder cell Full_adder_18ec068_behavioral (ports a, b, c, s, car); no other sub-modules are permitted.
REQ-030 All outputs SHALL be registered.

Verification (WIDTH=8)
REQ-031 Case 1: a_in=0x55, b_in=0xAA, cin=0, start for 1 cycle -> busy high for 8 cycles, then done pulse, sum_out=0xFF, cout=0.
REQ-032 Case 2: 0xFF + 0x01, cin=0 -> sum_out=0x00, cout=1; done exactly 8 edges after the start edge.
REQ-033 Case 3: 0xFF + 0xFF, cin=1 -> sum_out=0xFF, cout=1.
REQ-034 Case 4: 0x10 + 0x20 started, then start pulsed with 0x01 + 0x01 at bit-cycle 3 -> second request ignored; result is sum_out=0x30, cout=0.
REQ-035 Case 5: rst pulsed at bit-cycle 4 of 0x0F + 0x0F -> next cycle in IDLE with all outputs 0 and no done; a fresh start of 0x03 + 0x04 then yields 0x07.
REQ-036 Case 6 (SERIAL_ADDER_OVF_EN defined): 0x7F + 0x01 -> sum_out=0x80, ovf=1, cout=0; 0x80 + 0x80 -> sum_out=0x00, ovf=1, cout=1.
